// File: rtl/shift_rows_pipe_if.sv
// Block stream bundle for shift_rows_pipe: input side, output side and the per-block inv tag.
// master drives blocks in and consumes results; slave is the pipeline itself.
interface shift_rows_pipe_if #(
  parameter int NB = 4
);
  logic [0:32*NB-1] in;
  logic             in_valid;
  logic             in_ready;
  logic             inv;
  logic [0:32*NB-1] out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in, in_valid, inv, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, in_valid, inv, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Two-stage ShiftRows pipeline (S1 capture, S2 shifted result) with valid/ready on both sides.
// Defining SHIFT_ROWS_PIPE_INV_EN adds the per-block InvShiftRows path selected by inv.
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_rows_pipe_if.slave bus
);
  localparam int W = 32 * NB;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Row offsets: NB=8 uses 1,3,4 for rows 1..3, the narrower states use 1,2,3.
  function automatic int row_off(input int r);
    if (r == 0) return 0;
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic         s1_valid;
  logic [0:W-1] s1_data;
  logic         s2_valid;
  logic [0:W-1] s2_data;
  logic [0:W-1] fwd;
  logic [0:W-1] shifted;
  logic         s2_open;

  genvar gc, gr;
  generate
    for (gc = 0; gc < NB; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        localparam int SRC_C = (gc + row_off(gr)) % NB;
        assign fwd[8*(4*gc+gr) +: 8] = s1_data[8*(4*SRC_C+gr) +: 8];
      end
    end
  endgenerate

`ifdef SHIFT_ROWS_PIPE_INV_EN
  logic         s1_inv;
  logic [0:W-1] bwd;

  generate
    for (gc = 0; gc < NB; gc++) begin : g_icol
      for (gr = 0; gr < 4; gr++) begin : g_irow
        localparam int SRC_C = (gc - row_off(gr) + NB) % NB;
        assign bwd[8*(4*gc+gr) +: 8] = s1_data[8*(4*SRC_C+gr) +: 8];
      end
    end
  endgenerate

  assign shifted = s1_inv ? bwd : fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inv <= 1'b0;
    end else if (bus.in_ready && bus.in_valid) begin
      s1_inv <= bus.inv;
    end
  end
`else
  // Forward-only build: inv is accepted on the port but has no effect.
  logic inv_unused;
  assign inv_unused = bus.inv;
  assign shifted    = fwd;
`endif

  // S2 takes a new block when empty or when its current block retires this edge.
  assign s2_open      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_open;
  assign bus.out      = s2_data;
  assign bus.out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= bus.in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_open) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= shifted;
      end
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 and NB=8 instances, reset, latency, stream/backpressure.
module tb_shift_rows_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_rows_pipe_if #(.NB(4)) bus4 ();
  shift_rows_pipe_if #(.NB(8)) bus8 ();

  shift_rows_pipe #(.NB(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  shift_rows_pipe #(.NB(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int total = 0;
  int bad   = 0;

  localparam logic [0:127] PAT4 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [0:127] EXP4 = 128'h00050A0F04090E03080D02070C01060B;
  localparam logic [0:255] PAT8 =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [0:255] EXP8 =
    256'h00050E1304091217080D161B0C111A1F10151E0314190207181D060B1C010A0F;

  function automatic logic [0:127] xb(input logic [0:127] v, input logic [7:0] k);
    return v ^ {16{k}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.in = '0; bus4.in_valid = 1'b0; bus4.inv = 1'b0; bus4.out_ready = 1'b1;
    bus8.in = '0; bus8.in_valid = 1'b0; bus8.inv = 1'b0; bus8.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus4.out_valid); end
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus4.in_ready); end
    total++; if (bus4.out !== 128'h0) begin bad++; $display("FAIL rst_out got=%h want=0", bus4.out); end
    total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid8 got=%b want=0", bus8.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Block presented right after reset release; result visible two edges later.
  task automatic test_forward();
    bus4.in = PAT4; bus4.in_valid = 1'b1; bus4.inv = 1'b0; bus4.out_ready = 1'b1;
    #1;
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL fwd_in_ready got=%b want=1", bus4.in_ready); end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    #1;
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL fwd_early_valid got=%b want=0", bus4.out_valid); end
    @(negedge clk);
    #1;
    total++; if (bus4.out_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid got=%b want=1", bus4.out_valid); end
    total++; if (bus4.out !== EXP4) begin bad++; $display("FAIL fwd_data got=%h want=%h", bus4.out, EXP4); end
    @(negedge clk);
    #1;
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL fwd_retire got=%b want=0", bus4.out_valid); end
  endtask

  task automatic test_nb8();
    @(negedge clk);
    bus8.in = PAT8; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus8.out_valid !== 1'b1) begin bad++; $display("FAIL nb8_valid got=%b want=1", bus8.out_valid); end
    total++; if (bus8.out !== EXP8) begin bad++; $display("FAIL nb8_data got=%h want=%h", bus8.out, EXP8); end
  endtask

  task automatic test_inverse();
    logic [0:127] want_a;
    logic [0:127] want_b;
`ifdef SHIFT_ROWS_PIPE_INV_EN
    want_a = PAT4;
    want_b = EXP4;
    @(negedge clk);
    bus4.in = EXP4; bus4.inv = 1'b1; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in = PAT4; bus4.inv = 1'b0;
`else
    want_a = EXP4;
    want_b = xb(EXP4, 8'h5A);
    @(negedge clk);
    bus4.in = PAT4; bus4.inv = 1'b1; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in = xb(PAT4, 8'h5A); bus4.inv = 1'b1;
`endif
    #1;
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL inv_in_ready got=%b want=1", bus4.in_ready); end
    @(negedge clk);
    bus4.in_valid = 1'b0; bus4.inv = 1'b0;
    #1;
    total++; if (bus4.out_valid !== 1'b1 || bus4.out !== want_a) begin
      bad++; $display("FAIL inv_first got=%b/%h want=1/%h", bus4.out_valid, bus4.out, want_a);
    end
    @(negedge clk);
    #1;
    total++; if (bus4.out_valid !== 1'b1 || bus4.out !== want_b) begin
      bad++; $display("FAIL inv_second got=%b/%h want=1/%h", bus4.out_valid, bus4.out, want_b);
    end
    @(negedge clk);
  endtask

  // Streams n blocks (block i = PAT4 xor i) with out_ready low on cycles lo..hi.
  task automatic test_stream(input int n, input int lo, input int hi);
    int sent = 0;
    int recv = 0;
    int first = -1;
    logic hold_chk = 1'b0;
    logic exp_rdy;
    logic [0:127] held = '0;
    for (int cyc = 0; cyc < 80 && recv < n; cyc++) begin
      @(negedge clk);
      bus4.out_ready = !(cyc >= lo && cyc <= hi);
      bus4.in_valid  = (sent < n);
      bus4.in        = xb(PAT4, sent[7:0]);
      bus4.inv       = 1'b0;
      #1;
      if (hold_chk) begin
        total++;
        if (bus4.out_valid !== 1'b1 || bus4.out !== held) begin
          bad++; $display("FAIL stream_hold cyc=%0d got=%b/%h want=1/%h", cyc, bus4.out_valid, bus4.out, held);
        end
      end
      exp_rdy = (sent - recv < 2) || bus4.out_ready;
      total++;
      if (bus4.in_ready !== exp_rdy) begin
        bad++; $display("FAIL stream_in_ready cyc=%0d got=%b want=%b", cyc, bus4.in_ready, exp_rdy);
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (first < 0) first = cyc;
        total++;
        if (bus4.out !== xb(EXP4, recv[7:0])) begin
          bad++; $display("FAIL stream_data blk=%0d got=%h want=%h", recv, bus4.out, xb(EXP4, recv[7:0]));
        end
        recv++;
      end
      hold_chk = bus4.out_valid && !bus4.out_ready;
      held = bus4.out;
      if (bus4.in_valid && bus4.in_ready) sent++;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    total++; if (recv != n) begin bad++; $display("FAIL stream_count got=%0d want=%0d", recv, n); end
    total++; if (first != 2) begin bad++; $display("FAIL stream_latency got=%0d want=2", first); end
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL stream_extra got=%b want=0", bus4.out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus4.out_ready = 1'b0; bus4.in_valid = 1'b1; bus4.in = PAT4;
    @(negedge clk);
    bus4.in = xb(PAT4, 8'h01);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    #1;
    total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", bus4.in_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", bus4.out_valid); end
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus4.in_ready); end
    total++; if (bus4.out !== 128'h0) begin bad++; $display("FAIL mid_out got=%h want=0", bus4.out); end
    @(negedge clk);
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b want=0", i, bus4.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_nb8();
    test_inverse();
    test_stream(10, 3, 6);
    test_stream(6, 100, 100);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end
endmodule
